// File: rtl/seq_jkff_excite_driver.sv
// Drives J/K inputs of an external JK flip-flop bank until its Q matches a requested
// target word, retrying on mismatch and reporting done/err.
module seq_jkff_excite_driver #(
    parameter int unsigned N          = 4,
    parameter int unsigned USE_TOGGLE = 0,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_val,
    output logic         in_rdy,
    input  logic [N-1:0] target,
    input  logic [N-1:0] q,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         done,
    output logic         err
);

    localparam int unsigned RW = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    tgt_q, tgt_d;
    logic [N-1:0]    j_q, j_d;
    logic [N-1:0]    k_q, k_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [N-1:0]    exc_tgt;
    logic [N-1:0]    diff;
    logic [N-1:0]    j_exc;
    logic [N-1:0]    k_exc;

    // Excitation from the word being driven toward and the live bank feedback.
    always_comb begin
        exc_tgt = (state_q == S_IDLE) ? target : tgt_q;
        diff    = exc_tgt ^ q;
        if (USE_TOGGLE != 0) begin
            j_exc = diff;
            k_exc = diff;
        end else begin
            j_exc = diff & exc_tgt;
            k_exc = diff & ~exc_tgt;
        end
    end

    // Next-state and registered-output logic; j/k default to hold (0/0).
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = '0;
        k_d     = '0;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_val) begin
                    state_d = S_DRIVE;
                    tgt_d   = target;
                    j_d     = j_exc;
                    k_d     = k_exc;
                    retry_d = '0;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (q == tgt_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    state_d = S_DRIVE;
                    retry_d = retry_q + RW'(1);
                    j_d     = j_exc;
                    k_d     = k_exc;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_rdy = (state_q == S_IDLE);
    assign j      = j_q;
    assign k      = k_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seq_jkff_excite_driver.sv
// Directed bench: set/reset-form and toggle-form drivers run side by side, each
// feeding its own modelled JK bank with a shared stuck-at-0 mask.
module tb_seq_jkff_excite_driver;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_val;
    logic [N-1:0] target;
    logic [N-1:0] stuck;
    logic         bank_clr;

    logic [N-1:0] bank0, bank1, q0, q1;
    logic [N-1:0] j0, k0, j1, k1;
    logic         rdy0, rdy1, done0, done1, err0, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign q0 = bank0 & ~stuck;
    assign q1 = bank1 & ~stuck;

    // Q+ = J&~K | ~K&Q | J&K&~Q
    always @(posedge clk) begin
        if (bank_clr) begin
            bank0 <= '0;
            bank1 <= '0;
        end else begin
            bank0 <= (j0 & ~k0) | (~k0 & bank0) | (j0 & k0 & ~bank0);
            bank1 <= (j1 & ~k1) | (~k1 & bank1) | (j1 & k1 & ~bank1);
        end
    end

    seq_jkff_excite_driver #(.N(N), .USE_TOGGLE(0), .MAX_RETRY(2)) u_dut0 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy0), .target(target),
        .q(q0), .j(j0), .k(k0), .done(done0), .err(err0)
    );

    seq_jkff_excite_driver #(.N(N), .USE_TOGGLE(1), .MAX_RETRY(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy1), .target(target),
        .q(q1), .j(j1), .k(k1), .done(done1), .err(err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_both_status(input string tag, input logic d, input logic e, input logic r);
        check({tag, " done0"}, 32'(done0), 32'(d));
        check({tag, " err0"},  32'(err0),  32'(e));
        check({tag, " rdy0"},  32'(rdy0),  32'(r));
        check({tag, " done1"}, 32'(done1), 32'(d));
        check({tag, " err1"},  32'(err1),  32'(e));
        check({tag, " rdy1"},  32'(rdy1),  32'(r));
    endtask

    initial begin
        logic [N-1:0] exp_t;
        int           ndone;
        int           cyc;

        reset    = 1'b0;
        bank_clr = 1'b1;
        in_val   = 1'b0;
        target   = '0;
        stuck    = '0;
        exp_t    = '0;
        ndone    = 0;

        // Reset held low for two cycles, bank cleared alongside.
        tick();
        tick();
        check("rst j0", 32'(j0), 32'h0);
        check("rst k0", 32'(k0), 32'h0);
        check("rst j1", 32'(j1), 32'h0);
        check("rst k1", 32'(k1), 32'h0);
        check_both_status("rst", 1'b0, 1'b0, 1'b1);
        check("rst bank", 32'(q0), 32'h0);
        reset    = 1'b1;
        bank_clr = 1'b0;
        tick();

        // 0000 -> 1010
        in_val = 1'b1; target = 4'b1010;
        tick();
        in_val = 1'b0;
        check("t1 drive j0", 32'(j0), 32'b1010);
        check("t1 drive k0", 32'(k0), 32'b0000);
        check("t1 drive j1", 32'(j1), 32'b1010);
        check("t1 drive k1", 32'(k1), 32'b1010);
        check_both_status("t1 drive", 1'b0, 1'b0, 1'b0);
        tick();
        check("t1 chk j0", 32'(j0), 32'h0);
        check("t1 chk k1", 32'(k1), 32'h0);
        check("t1 chk done0", 32'(done0), 32'h0);
        tick();
        check_both_status("t1 done", 1'b1, 1'b0, 1'b1);
        check("t1 q0", 32'(q0), 32'b1010);
        check("t1 q1", 32'(q1), 32'b1010);
        tick();
        check("t1 done pulse", 32'(done0), 32'h0);

        // 1010 -> 0110
        in_val = 1'b1; target = 4'b0110;
        tick();
        in_val = 1'b0;
        check("t2 drive j0", 32'(j0), 32'b0100);
        check("t2 drive k0", 32'(k0), 32'b1000);
        check("t2 drive j1", 32'(j1), 32'b1100);
        check("t2 drive k1", 32'(k1), 32'b1100);
        tick();
        tick();
        check_both_status("t2 done", 1'b1, 1'b0, 1'b1);
        check("t2 q0", 32'(q0), 32'b0110);
        check("t2 q1", 32'(q1), 32'b0110);
        tick();

        // q[0] stuck at 0, target 0001: three drives then err.
        stuck  = 4'b0001;
        in_val = 1'b1; target = 4'b0001;
        tick();
        in_val = 1'b0;
        check("t3 drv1 j0[0]", 32'(j0[0]), 32'h1);
        check("t3 drv1 j1[0]", 32'(j1[0]), 32'h1);
        check("t3 drv1 k0", 32'(k0), 32'b0110);
        tick();
        tick();
        check_both_status("t3 drv2", 1'b0, 1'b0, 1'b0);
        check("t3 drv2 j0", 32'(j0), 32'b0001);
        check("t3 drv2 k0", 32'(k0), 32'b0000);
        check("t3 drv2 j1", 32'(j1), 32'b0001);
        tick();
        tick();
        check("t3 drv3 j0[0]", 32'(j0[0]), 32'h1);
        check("t3 drv3 j1[0]", 32'(j1[0]), 32'h1);
        check("t3 drv3 done0", 32'(done0), 32'h0);
        tick();
        check("t3 chk3 done0", 32'(done0), 32'h0);
        tick();
        check_both_status("t3 err", 1'b1, 1'b1, 1'b1);
        stuck = '0;
        tick();
        check("t3 err pulse", 32'(err0), 32'h0);
        check("t3 bank0", 32'(q0), 32'b0001);
        check("t3 bank1", 32'(q1), 32'b0001);

        // Reset asserted during DRIVE aborts the transaction.
        in_val = 1'b1; target = 4'b1000;
        tick();
        in_val = 1'b0;
        check("t4 in drive rdy0", 32'(rdy0), 32'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t4 rst j0", 32'(j0), 32'h0);
        check("t4 rst k0", 32'(k0), 32'h0);
        check("t4 rst k1", 32'(k1), 32'h0);
        check_both_status("t4 rst", 1'b0, 1'b0, 1'b1);
        tick();
        check("t4 no done a", 32'(done0 | done1), 32'h0);
        tick();
        check("t4 no done b", 32'(done0 | done1), 32'h0);
        in_val = 1'b1; target = 4'b0101;
        tick();
        in_val = 1'b0;
        tick();
        tick();
        check_both_status("t4 new done", 1'b1, 1'b0, 1'b1);
        check("t4 q0", 32'(q0), 32'b0101);
        check("t4 q1", 32'(q1), 32'b0101);

        // Back-to-back: second target accepted in the first done cycle.
        in_val = 1'b1; target = 4'b0011;
        tick();
        in_val = 1'b0;
        tick();
        tick();
        check_both_status("t5 done a", 1'b1, 1'b0, 1'b1);
        check("t5 q0 a", 32'(q0), 32'b0011);
        in_val = 1'b1; target = 4'b1100;
        tick();
        in_val = 1'b0;
        check("t5 gap1", 32'(done0), 32'h0);
        check("t5 drive j0", 32'(j0), 32'b1100);
        check("t5 drive k0", 32'(k0), 32'b0011);
        tick();
        check("t5 gap2", 32'(done0), 32'h0);
        tick();
        check_both_status("t5 done b", 1'b1, 1'b0, 1'b1);
        check("t5 q0 b", 32'(q0), 32'b1100);
        check("t5 q1 b", 32'(q1), 32'b1100);

        // Random targets with random in_val.
        cyc = 0;
        while (ndone < 50 && cyc < 3000) begin
            in_val = 1'($urandom_range(0, 1));
            target = N'($urandom);
            if (in_val && rdy0) exp_t = target;
            tick();
            cyc++;
            if ((j0 & k0) != '0) check("rnd j0&k0", 32'(j0 & k0), 32'h0);
            if (done0) begin
                check("rnd err0", 32'(err0), 32'h0);
                check("rnd q0", 32'(q0), 32'(exp_t));
                check("rnd err1", 32'(err1), 32'h0);
                check("rnd q1", 32'(q1), 32'(exp_t));
                ndone++;
            end
        end
        in_val = 1'b0;
        check("rnd done count", 32'(ndone), 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
